rc4_phase_sequencer: RTL

- Top-level scheduler for the 256-entry S-memory in the RC4 datapath.
- Runs three memory clients strictly in order: identity init (s[i]=i), key-schedule shuffle, then decrypt.
- Each client gets a one-cycle start pulse; the sequencer waits for its finish.
- Owns the single S-memory write port: routes only the active client's address/data/wren to memory and blocks all others.

---
 rtl/rc4_phase_sequencer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/rc4_phase_sequencer.sv
// Sequences the RC4 S-memory clients (init, KSA, decrypt) and owns the shared write port.
// Optional per-phase watchdog compiled in with `define RC4_PHASE_TIMEOUT_EN.
module rc4_phase_sequencer #(
   parameter int AW             = 8,
   parameter int DW             = 8,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [1:0]    phase,
   output logic          error,
   output logic          c0_start,
   output logic          c1_start,
   output logic          c2_start,
   input  logic          c0_finish,
   input  logic          c1_finish,
   input  logic          c2_finish,
   input  logic [AW-1:0] c0_address,
   input  logic [DW-1:0] c0_data,
   input  logic          c0_wren,
   input  logic [AW-1:0] c1_address,
   input  logic [DW-1:0] c1_data,
   input  logic          c1_wren,
   input  logic [AW-1:0] c2_address,
   input  logic [DW-1:0] c2_data,
   input  logic          c2_wren,
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_data,
   output logic          mem_wren
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_L_INIT,
      S_W_INIT,
      S_L_KSA,
      S_W_KSA,
      S_L_DEC,
      S_W_DEC,
      S_FIN
   } state_t;

   state_t     r_state;
   logic       r_busy;
   logic       r_done;
   logic [1:0] r_phase;
   logic       r_c0_start;
   logic       r_c1_start;
   logic       r_c2_start;
   logic       w_finish;
   logic       w_in_wait;
   logic       w_timeout;

   // Only the active phase's finish is visible, so stale levels from idle clients are ignored.
   always_comb begin
      w_finish = 1'b0;
      case (r_state)
         S_W_INIT: w_finish = c0_finish;
         S_W_KSA:  w_finish = c1_finish;
         S_W_DEC:  w_finish = c2_finish;
         default:  w_finish = 1'b0;
      endcase
   end

   assign w_in_wait = (r_state == S_W_INIT) || (r_state == S_W_KSA) || (r_state == S_W_DEC);

`ifdef RC4_PHASE_TIMEOUT_EN
   localparam logic [15:0] LP_LIMIT = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] r_wdog;
   logic        r_error;

   // Finish has priority over an expiring watchdog in the same cycle.
   assign w_timeout = w_in_wait && !w_finish && (r_wdog == LP_LIMIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wdog  <= '0;
         r_error <= 1'b0;
      end else begin
         if (w_in_wait)
            r_wdog <= r_wdog + 16'd1;
         else
            r_wdog <= '0;
         if (w_timeout)
            r_error <= 1'b1;
         else if (r_state == S_IDLE && start)
            r_error <= 1'b0;
      end
   end

   assign error = r_error;
`else
   assign w_timeout = 1'b0;
   assign error     = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_phase    <= 2'd0;
         r_c0_start <= 1'b0;
         r_c1_start <= 1'b0;
         r_c2_start <= 1'b0;
      end else begin
         r_c0_start <= 1'b0;
         r_c1_start <= 1'b0;
         r_c2_start <= 1'b0;
         r_done     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_L_INIT;
                  r_busy     <= 1'b1;
                  r_phase    <= 2'd1;
                  r_c0_start <= 1'b1;
               end
            end
            S_L_INIT: r_state <= S_W_INIT;
            S_W_INIT: begin
               if (w_finish) begin
                  r_state    <= S_L_KSA;
                  r_phase    <= 2'd2;
                  r_c1_start <= 1'b1;
               end else if (w_timeout) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_phase <= 2'd0;
               end
            end
            S_L_KSA: r_state <= S_W_KSA;
            S_W_KSA: begin
               if (w_finish) begin
                  r_state    <= S_L_DEC;
                  r_phase    <= 2'd3;
                  r_c2_start <= 1'b1;
               end else if (w_timeout) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_phase <= 2'd0;
               end
            end
            S_L_DEC: r_state <= S_W_DEC;
            S_W_DEC: begin
               if (w_finish) begin
                  r_state <= S_FIN;
                  r_phase <= 2'd0;
                  r_done  <= 1'b1;
               end else if (w_timeout) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_phase <= 2'd0;
               end
            end
            S_FIN: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_phase <= 2'd0;
            end
         endcase
      end
   end

   // Write-port mux keyed off the registered phase; idle forces everything low.
   always_comb begin
      mem_address = '0;
      mem_data    = '0;
      mem_wren    = 1'b0;
      case (r_phase)
         2'd1: begin
            mem_address = c0_address;
            mem_data    = c0_data;
            mem_wren    = c0_wren;
         end
         2'd2: begin
            mem_address = c1_address;
            mem_data    = c1_data;
            mem_wren    = c1_wren;
         end
         2'd3: begin
            mem_address = c2_address;
            mem_data    = c2_data;
            mem_wren    = c2_wren;
         end
         default: begin
            mem_address = '0;
            mem_data    = '0;
            mem_wren    = 1'b0;
         end
      endcase
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign phase    = r_phase;
   assign c0_start = r_c0_start;
   assign c1_start = r_c1_start;
   assign c2_start = r_c2_start;

endmodule
